lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 142 ++++++++++++++
 tb/tb_lfsr_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Serial checker for the 32-bit XNOR LFSR stream: acquires the generator state from din,
// verifies it, then counts bit errors in LOCKED and drops lock on too many errors per window.
module lfsr_checker #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        din,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int ERR_W = $clog2(LOSS_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(LOSS_THRESH);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       sh_reg, sh_next;
    logic [4:0]        cnt_reg, cnt_next;
    logic [WIN_W-1:0]  win_bit_reg, win_bit_next;
    logic [ERR_W-1:0]  win_err_reg, win_err_next;
    logic [ERR_W-1:0]  win_err_inc;
    logic [31:0]       sh_loaded;
    logic              err_pulse_reg;
    logic [15:0]       err_count_reg;
    logic [31:0]       bit_count_reg;
    logic              pred;
    logic              mismatch;
    logic              bit_event;
    logic              err_event;

    assign pred      = ~(sh_reg[31] ^ sh_reg[21] ^ sh_reg[1] ^ sh_reg[0]);
    assign mismatch  = din ^ pred;
    assign bit_event = enable && (state_reg == LOCKED);
    assign err_event = bit_event && mismatch;
    assign sh_loaded = {sh_reg[30:0], din};

    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        cnt_next     = cnt_reg;
        win_bit_next = win_bit_reg;
        win_err_next = win_err_reg;
        win_err_inc  = win_err_reg + ERR_W'(mismatch);
        if (enable) begin
            case (state_reg)
                HUNT: begin
                    sh_next = sh_loaded;
                    if (cnt_reg == 5'd31) begin
                        cnt_next = 5'd0;
                        // The all-ones word is the XNOR lockup state and is never a valid load.
                        if (sh_loaded != 32'hFFFF_FFFF) begin
                            state_next = VERIFY;
                        end
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_next = HUNT;
                        cnt_next   = 5'd0;
                    end else begin
                        sh_next = {sh_reg[30:0], pred};
                        if (cnt_reg == 5'd31) begin
                            state_next   = LOCKED;
                            cnt_next     = 5'd0;
                            win_bit_next = '0;
                            win_err_next = '0;
                        end else begin
                            cnt_next = cnt_reg + 5'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so channel errors never enter the shadow.
                    sh_next = {sh_reg[30:0], pred};
                    if (mismatch && (win_err_inc == ERR_LIMIT)) begin
                        state_next   = HUNT;
                        cnt_next     = 5'd0;
                        win_bit_next = '0;
                        win_err_next = '0;
                    end else if (win_bit_reg == WIN_LAST) begin
                        win_bit_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_bit_next = win_bit_reg + WIN_W'(1);
                        win_err_next = win_err_inc;
                    end
                end
                default: begin
                    state_next = HUNT;
                    cnt_next   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= HUNT;
            sh_reg        <= 32'h0000_0000;
            cnt_reg       <= 5'd0;
            win_bit_reg   <= '0;
            win_err_reg   <= '0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= 16'd0;
            bit_count_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            sh_reg        <= sh_next;
            cnt_reg       <= cnt_next;
            win_bit_reg   <= win_bit_next;
            win_err_reg   <= win_err_next;
            err_pulse_reg <= err_event;
            if (clear) begin
                err_count_reg <= 16'd0;
            end else if (err_event && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            if (clear) begin
                bit_count_reg <= 32'd0;
            end else if (bit_event && (bit_count_reg != 32'hFFFF_FFFF)) begin
                bit_count_reg <= bit_count_reg + 32'd1;
            end
        end
    end

    assign locked    = (state_reg == LOCKED);
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenario table, hand-written corner
// sequences and randomized traffic, all compared against a run-length based reference model.
module tb_lfsr_checker;

    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 8;
    localparam logic [31:0] SEED = 32'hFFFF_0FFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        din = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    int checks = 0;
    int failures = 0;

    lfsr_checker #(.WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Reference generator state.
    logic [31:0] gen;

    // Reference model: acquisition is a run length of accepted bits (0..31 load, 32..63 verify).
    logic        m_lk, m_pulse;
    logic [31:0] m_hist;
    int          m_run, m_win_pos, m_win_err;
    longint      m_err, m_bits;

    function automatic logic predict(input logic [31:0] h);
        return ~(h[31] ^ h[21] ^ h[1] ^ h[0]);
    endfunction

    task automatic gen_bit(output logic b);
        b   = predict(gen);
        gen = {gen[30:0], b};
    endtask

    task automatic model_update(input logic en, input logic d, input logic clr, input logic rst);
        logic p;
        if (rst) begin
            m_lk = 0; m_pulse = 0; m_hist = '0; m_run = 0;
            m_win_pos = 0; m_win_err = 0; m_err = 0; m_bits = 0;
            return;
        end
        m_pulse = 0;
        if (en) begin
            p = predict(m_hist);
            if (!m_lk) begin
                if (m_run < 32) begin
                    m_hist = {m_hist[30:0], d};
                    m_run++;
                    if (m_run == 32 && m_hist == 32'hFFFF_FFFF) m_run = 0;
                end else if (d != p) begin
                    m_run = 0;
                end else begin
                    m_hist = {m_hist[30:0], p};
                    m_run++;
                    if (m_run == 64) begin
                        m_lk = 1; m_win_pos = 0; m_win_err = 0;
                    end
                end
            end else begin
                m_hist = {m_hist[30:0], p};
                if (m_bits < 64'h0000_0000_FFFF_FFFF) m_bits++;
                m_win_pos++;
                if (d != p) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_win_err++;
                end
                if (d != p && m_win_err == LOSS_THRESH) begin
                    m_lk = 0; m_run = 0; m_win_pos = 0; m_win_err = 0;
                end else if (m_win_pos == WINDOW) begin
                    m_win_pos = 0; m_win_err = 0;
                end
            end
        end
        if (clr) begin
            m_err = 0; m_bits = 0;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic clr, input logic rst);
        enable = en; din = d; clear = clr; reset = rst;
        @(posedge clk);
        model_update(en, d, clr, rst);
        #1;
        chk("model_locked", longint'(locked), longint'(m_lk));
        chk("model_err_pulse", longint'(err_pulse), longint'(m_pulse));
        chk("model_err_count", longint'(err_count), m_err);
        chk("model_bit_count", longint'(bit_count), m_bits);
    endtask

    task automatic send(input logic inv, input logic clr);
        logic b;
        gen_bit(b);
        step(1'b1, b ^ inv, clr, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        gen = SEED;
    endtask

    task automatic expect_out(input string name, input logic l, input logic p,
                              input longint e, input longint b);
        chk({name, "_locked"}, longint'(locked), longint'(l));
        chk({name, "_err_pulse"}, longint'(err_pulse), longint'(p));
        chk({name, "_err_count"}, longint'(err_count), e);
        chk({name, "_bit_count"}, longint'(bit_count), b);
    endtask

    typedef struct {
        int     n_bits;
        int     err_at;
        logic   exp_locked;
        logic   exp_pulse;
        longint exp_err;
        longint exp_bits;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{63, 0, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{64, 0, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{70, 0, 1'b1, 1'b0, 0, 6};
        vecs[3] = '{64, 64, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{127, 64, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{128, 64, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{103, 40, 1'b0, 1'b0, 0, 0};
        vecs[7] = '{104, 40, 1'b1, 1'b0, 0, 0};
        vecs[8] = '{65, 65, 1'b1, 1'b1, 1, 1};
        vecs[9] = '{80, 70, 1'b1, 1'b0, 1, 16};

        // Reset state.
        do_reset();
        expect_out("reset", 1'b0, 1'b0, 0, 0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            for (int k = 1; k <= vecs[v].n_bits; k++) send(k == vecs[v].err_at, 1'b0);
            expect_out($sformatf("vec%0d", v), vecs[v].exp_locked, vecs[v].exp_pulse,
                       vecs[v].exp_err, vecs[v].exp_bits);
            $display("vector %0d: bits=%0d err_at=%0d locked=%0b err_count=%0d bit_count=%0d",
                     v, vecs[v].n_bits, vecs[v].err_at, locked, err_count, bit_count);
        end

        // Loss of lock: 8 errors within one window, then relock.
        do_reset();
        for (int k = 0; k < 64; k++) send(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0);
            if (i == 6) expect_out("loss_7th", 1'b1, 1'b1, 7, 13);
            if (i < 7) send(1'b0, 1'b0);
        end
        expect_out("loss_8th", 1'b0, 1'b1, 8, 15);
        for (int k = 0; k < 63; k++) send(1'b0, 1'b0);
        expect_out("relock_63", 1'b0, 1'b0, 8, 15);
        send(1'b0, 1'b0);
        expect_out("relock_64", 1'b1, 1'b0, 8, 15);
        $display("loss of lock: err_count=%0d relocked=%0b", err_count, locked);

        // Eight errors straddling a window boundary keep lock.
        do_reset();
        for (int k = 0; k < 124; k++) send(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, 1'b0);
        expect_out("straddle", 1'b1, 1'b1, 8, 68);
        for (int k = 0; k < 10; k++) send(1'b0, 1'b0);
        expect_out("straddle_after", 1'b1, 1'b0, 8, 78);
        $display("window straddle: locked=%0b err_count=%0d", locked, err_count);

        // Lockup rejection: 32 ones then a valid stream.
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 63; k++) send(1'b0, 1'b0);
        expect_out("lockup_63", 1'b0, 1'b0, 0, 0);
        send(1'b0, 1'b0);
        expect_out("lockup_64", 1'b1, 1'b0, 0, 0);
        $display("lockup rejection: locked=%0b", locked);

        // Clear coincident with an error, then enable gaps.
        do_reset();
        for (int k = 0; k < 64; k++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        expect_out("pre_clear", 1'b1, 1'b1, 1, 1);
        send(1'b1, 1'b1);
        expect_out("clear_err", 1'b1, 1'b1, 0, 0);
        send(1'b1, 1'b0);
        expect_out("post_clear", 1'b1, 1'b1, 1, 1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            expect_out("gap", 1'b1, 1'b0, 1, 1);
        end
        for (int k = 0; k < 5; k++) send(1'b0, 1'b0);
        expect_out("after_gap", 1'b1, 1'b0, 1, 6);
        $display("clear/gap: err_count=%0d bit_count=%0d", err_count, bit_count);

        // Reset while locked, with enable and clear also asserted.
        begin
            logic b;
            gen_bit(b);
            step(1'b1, ~b, 1'b1, 1'b1);
        end
        expect_out("reset_locked", 1'b0, 1'b0, 0, 0);
        $display("reset while locked: locked=%0b err_count=%0d", locked, err_count);

        // Randomized traffic against the model, segment by segment with varying error rates.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            int rate;
            rate = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 40 : 6);
            gen = $urandom();
            if (gen == 32'hFFFF_FFFF) gen = SEED;
            for (int c = 0; c < 500; c++) begin
                logic en, inv, clr, rst, b;
                en  = ($urandom_range(0, 9) != 0);
                inv = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
                clr = ($urandom_range(0, 149) == 0);
                rst = ($urandom_range(0, 1999) == 0);
                if (en) begin
                    gen_bit(b);
                    b = b ^ inv;
                end else begin
                    b = 1'($urandom_range(0, 1));
                end
                step(en, b, clr, rst);
            end
            $display("random segment %0d: locked=%0b err_count=%0d bit_count=%0d",
                     seg, locked, err_count, bit_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
